// File: rtl/md_sequencer.sv
// md_sequencer: iterative multiply/divide sequencer for ALU codes 1100-1111
//   (shift-add multiplier / restoring divider, one bit per cycle, sign fix inside).
// Latency: done pulses WIDTH+2 edges after accept (2 edges for divide-by-zero).
// Backpressure: busy stalls the pipeline; start outside IDLE is dropped, abort cancels.
//
// Optional build macro MD_EARLY_TERM_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are all zero (variable latency, identical results).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, alu_ctrl   request and operation (1100 umul, 1101 udiv, 1110 smul, 1111 sdiv)
//   op_a, op_b        multiplicand/dividend, multiplier/divisor
//   abort             pipeline flush, cancels an operation in flight
//   busy, done        stall indication and one-cycle completion pulse
//   div_by_zero       sticky until the next accepted start
//   hi, lo            product high/low, or remainder/quotient
module md_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREP = 2'd1;
   localparam logic [1:0] S_CALC = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q, b_q;
   logic             is_div, is_signed;
   logic             sign_q, sign_r, dbz;
   // acc: upper product half / partial remainder
   // mq : multiplier shifting out, product low half / dividend shifting into quotient
   // dvsr: multiplicand or divisor magnitude
   logic [WIDTH-1:0] acc, mq, dvsr;

   // operand magnitudes for PREP
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;

   always_comb begin
      a_neg = is_signed & a_q[WIDTH-1];
      b_neg = is_signed & b_q[WIDTH-1];
      a_abs = a_neg ? (~a_q + 1'b1) : a_q;
      b_abs = b_neg ? (~b_q + 1'b1) : b_q;
   end

   // one multiply iteration: conditional add, then shift {carry, acc, mq} right
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc_n, mul_mq_n;

   always_comb begin
      mul_sum   = {1'b0, acc} + {1'b0, (mq[0] ? dvsr : {WIDTH{1'b0}})};
      mul_acc_n = mul_sum[WIDTH:1];
      mul_mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
   end

   // one restoring-divide iteration; the shifted remainder may carry a bit
   // above WIDTH, but then it is >= divisor and the WIDTH-bit difference fits.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] div_diff, div_rem_n, div_quo_n;
   logic             div_ok;

   always_comb begin
      rem_sh    = {acc, mq[WIDTH-1]};
      div_ok    = (rem_sh >= {1'b0, dvsr});
      div_diff  = rem_sh[WIDTH-1:0] - dvsr;
      div_rem_n = div_ok ? div_diff : rem_sh[WIDTH-1:0];
      div_quo_n = {mq[WIDTH-2:0], div_ok};
   end

   // next CALC values and exit decision
   logic [WIDTH-1:0] calc_acc, calc_mq;
   logic             calc_done;
`ifdef MD_EARLY_TERM_EN
   logic [CNT_W-1:0] rem_cnt;
   logic [WIDTH-1:0] rem_mask;
`endif

   always_comb begin
      calc_acc  = is_div ? div_rem_n : mul_acc_n;
      calc_mq   = is_div ? div_quo_n : mul_mq_n;
      calc_done = (cnt == CNT_ONE);
`ifdef MD_EARLY_TERM_EN
      // low rem_cnt bits of mul_mq_n are the multiplier bits not yet consumed;
      // if they are all zero the rest of the run is pure shifting.
      rem_cnt  = cnt - CNT_ONE;
      rem_mask = ~({WIDTH{1'b1}} << rem_cnt);
      if (!is_div && ((mul_mq_n & rem_mask) == {WIDTH{1'b0}})) begin
         {calc_acc, calc_mq} = {mul_acc_n, mul_mq_n} >> rem_cnt;
         calc_done = 1'b1;
      end
`endif
   end

   // sign post-correction
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   always_comb begin
      prod_fix = sign_q ? (~{acc, mq} + 1'b1) : {acc, mq};
      quot_fix = sign_q ? (~mq + 1'b1) : mq;
      rem_fix  = sign_r ? (~acc + 1'b1) : acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         is_div      <= 1'b0;
         is_signed   <= 1'b0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         dbz         <= 1'b0;
         acc         <= '0;
         mq          <= '0;
         dvsr        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= 1'b0;
         if (abort && (state != S_IDLE)) begin
            // flush wins over everything, including completion in FIX
            state <= S_IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start && (alu_ctrl[3:2] == 2'b11)) begin
                     a_q         <= op_a;
                     b_q         <= op_b;
                     is_div      <= alu_ctrl[0];
                     is_signed   <= alu_ctrl[1];
                     busy        <= 1'b1;
                     div_by_zero <= 1'b0;
                     state       <= S_PREP;
                  end
               end
               S_PREP: begin
                  sign_q <= a_neg ^ b_neg;
                  sign_r <= a_neg;
                  acc    <= '0;
                  mq     <= is_div ? a_abs : b_abs;
                  dvsr   <= is_div ? b_abs : a_abs;
                  if (is_div && (b_q == {WIDTH{1'b0}})) begin
                     dbz   <= 1'b1;
                     state <= S_FIX;
                  end else begin
                     dbz   <= 1'b0;
                     cnt   <= CNT_INIT;
                     state <= S_CALC;
                  end
               end
               S_CALC: begin
                  acc <= calc_acc;
                  mq  <= calc_mq;
                  cnt <= cnt - CNT_ONE;
                  if (calc_done) state <= S_FIX;
               end
               S_FIX: begin
                  if (dbz) begin
                     lo          <= {WIDTH{1'b1}};
                     hi          <= a_q;
                     div_by_zero <= 1'b1;
                  end else if (is_div) begin
                     lo <= quot_fix;
                     hi <= rem_fix;
                  end else begin
                     {hi, lo} <= prod_fix;
                  end
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
